// File: rtl/hmc_mem_pkg.sv
// Shared types and constants for the HMC link-initialisation responder.
package hmc_mem_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_INIT_WAIT = 3'd1,
    ST_NULL_TX   = 3'd2,
    ST_TS1_TX    = 3'd3,
    ST_ACTIVE    = 3'd4,
    ST_SLEEP     = 3'd5,
    ST_ERROR     = 3'd6
  } link_state_e;

  localparam logic [7:0] TS1_HDR = 8'hF0;
  localparam logic [3:0] TS1_ID  = 4'hC;
  localparam int         SLOT_W  = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hmc_ts1_gen.sv
// TS1 training pattern generator: every lane carries identical 16-bit slots
// {F0, C, seq}, lower slot first, with seq advancing one step per slot.
module hmc_ts1_gen
  import hmc_mem_pkg::*;
#(
  parameter int NUM_LANES = 8,
  parameter int DWIDTH    = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  output logic [DWIDTH-1:0] pattern
);

  localparam int LANE_W = DWIDTH / NUM_LANES;
  localparam int SLOTS  = LANE_W / SLOT_W;

  // seq_q is the sequence number of the lowest slot of the next word to go out
  logic [3:0] seq_q;

  // Sequence register: 4-bit arithmetic gives the 15 -> 0 wrap for free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q <= 4'd0;
    end else if (clear) begin
      seq_q <= 4'd0;
    end else if (advance) begin
      seq_q <= seq_q + 4'(SLOTS);
    end
  end

  // Replicate the slot pattern across every lane
  always_comb begin
    pattern = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int s = 0; s < SLOTS; s++) begin
        pattern[l*LANE_W + s*SLOT_W +: SLOT_W] = {TS1_HDR, TS1_ID, 4'(seq_q + 4'(s))};
      end
    end
  end

endmodule

// File: rtl/hmc_link_init_responder.sv
// Device-side HMC link bring-up responder: power-on wait, NULL and TS1
// training, active payload forwarding, sleep handshake and fatal timeout.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   RESET      | held by P_RST_N low; outputs idle
//   INIT_WAIT  | T_INIT cycles after P_RST_N rises
//   NULL_TX    | drive all-zero NULLs for T_RESP1 cycles
//   TS1_TX     | drive TS1; wait for T_RESP2 cycles and NULL_DET zero cycles
//   ACTIVE     | forward flit payload, 1-cycle latency
//   SLEEP      | link idle; LXTXPS drops T_PD cycles after entry
//   ERROR      | training timed out; FERR_N low until P_RST_N pulse
module hmc_link_init_responder
  import hmc_mem_pkg::*;
#(
  parameter int DWIDTH    = 256,
  parameter int NUM_LANES = 8,
  parameter int T_INIT    = 64,
  parameter int T_RESP1   = 1500,
  parameter int T_RESP2   = 1000,
  parameter int NULL_DET  = 16,
  parameter int T_TIMEOUT = 65535,
  parameter int T_PD      = 32
) (
  input  logic              hmc_clk,
  input  logic              hmc_res_n,
  input  logic              P_RST_N,
  input  logic              LXRXPS,
  output logic              LXTXPS,
  output logic              FERR_N,
  input  logic [DWIDTH-1:0] phy_data_tx_link2phy,
  output logic [DWIDTH-1:0] phy_data_rx_phy2link,
  output logic              phy_rx_ready,
  input  logic [DWIDTH-1:0] flit_data,
  input  logic              flit_valid,
  output logic              flit_ready,
  output logic [2:0]        state_o
);

  localparam int T_MAX  = max_int(max_int(max_int(T_INIT, T_RESP1), max_int(T_RESP2, T_TIMEOUT)), T_PD);
  localparam int CNT_W  = $clog2(T_MAX) + 1;
  localparam int ZRUN_W = $clog2(NULL_DET) + 1;

  // Compare against "last cycle index" so a state lasts exactly N cycles
  localparam logic [CNT_W-1:0]  INIT_LAST    = CNT_W'(T_INIT - 1);
  localparam logic [CNT_W-1:0]  RESP1_LAST   = CNT_W'(T_RESP1 - 1);
  localparam logic [CNT_W-1:0]  RESP2_LAST   = CNT_W'(T_RESP2 - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(T_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  PD_LAST      = CNT_W'(T_PD - 1);
  localparam logic [ZRUN_W-1:0] ZRUN_LAST    = ZRUN_W'(NULL_DET - 1);

  link_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [ZRUN_W-1:0] zrun_q;
  logic [DWIDTH-1:0] ts1_pattern;
  logic [DWIDTH-1:0] data_d, data_q;
  logic              lxtxps_q, ferr_n_q, rx_ready_q;
  logic              tx_zero, train_done, entering;

  assign tx_zero    = (phy_data_tx_link2phy == '0);
  // Current cycle counts toward both the minimum length and the zero run
  assign train_done = (cnt_q >= RESP2_LAST) && tx_zero && (zrun_q >= ZRUN_LAST);
  assign entering   = (state_d != state_q);

  hmc_ts1_gen #(
    .NUM_LANES (NUM_LANES),
    .DWIDTH    (DWIDTH)
  ) u_ts1_gen (
    .clk     (hmc_clk),
    .rst_n   (hmc_res_n),
    .clear   (state_d != ST_TS1_TX),
    .advance (state_d == ST_TS1_TX),
    .pattern (ts1_pattern)
  );

  // State register and per-state counters, both cleared on every state entry
  always_ff @(posedge hmc_clk or negedge hmc_res_n) begin
    if (!hmc_res_n) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      zrun_q  <= '0;
    end else begin
      state_q <= state_d;
      if (entering) begin
        cnt_q  <= '0;
        zrun_q <= '0;
      end else begin
        if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        if (state_q == ST_TS1_TX) begin
          if (!tx_zero)           zrun_q <= '0;
          else if (zrun_q != '1)  zrun_q <= zrun_q + 1'b1;
        end
      end
    end
  end

  // Next-state logic; P_RST_N low overrides everything
  always_comb begin
    state_d = state_q;
    if (!P_RST_N) begin
      state_d = ST_RESET;
    end else begin
      case (state_q)
        ST_RESET:     state_d = ST_INIT_WAIT;
        ST_INIT_WAIT: if (cnt_q >= INIT_LAST)  state_d = ST_NULL_TX;
        ST_NULL_TX:   if (cnt_q >= RESP1_LAST) state_d = ST_TS1_TX;
        ST_TS1_TX: begin
          if (train_done)                  state_d = ST_ACTIVE;
          else if (cnt_q >= TIMEOUT_LAST)  state_d = ST_ERROR;
        end
        ST_ACTIVE:    if (!LXRXPS) state_d = ST_SLEEP;
        ST_SLEEP:     if (LXRXPS)  state_d = ST_NULL_TX;
        ST_ERROR:     state_d = ST_ERROR;
        default:      state_d = ST_RESET;
      endcase
    end
  end

  // Output data select; a beat accepted on the cycle ACTIVE is left is dropped
  always_comb begin
    data_d = '0;
    if (state_d == ST_TS1_TX) begin
      data_d = ts1_pattern;
    end else if (state_q == ST_ACTIVE && state_d == ST_ACTIVE && flit_valid) begin
      data_d = flit_data;
    end
  end

  // Registered outputs, derived from the next state so they line up with state_o
  always_ff @(posedge hmc_clk or negedge hmc_res_n) begin
    if (!hmc_res_n) begin
      data_q     <= '0;
      lxtxps_q   <= 1'b1;
      ferr_n_q   <= 1'b1;
      rx_ready_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      lxtxps_q   <= !(state_q == ST_SLEEP && state_d == ST_SLEEP && cnt_q >= PD_LAST);
      ferr_n_q   <= (state_d != ST_ERROR);
      rx_ready_q <= (state_d == ST_NULL_TX) || (state_d == ST_TS1_TX) ||
                    (state_d == ST_ACTIVE)  || (state_d == ST_SLEEP);
    end
  end

  assign phy_data_rx_phy2link = data_q;
  assign LXTXPS               = lxtxps_q;
  assign FERR_N               = ferr_n_q;
  assign phy_rx_ready         = rx_ready_q;
  assign flit_ready           = (state_q == ST_ACTIVE);
  assign state_o              = state_q;

endmodule

// File: tb/tb_hmc_link_init_responder.sv
// Bench for hmc_link_init_responder: randomized training, payload and sleep
// scenarios checked against expectations computed from the link rules.
module tb_hmc_link_init_responder;
  import hmc_mem_pkg::*;

  localparam int DW  = 256;
  localparam int NL  = 8;
  localparam int TI  = 4;
  localparam int TR1 = 10;
  localparam int TR2 = 8;
  localparam int ND  = 3;
  localparam int TTO = 20;
  localparam int TPD = 5;
  localparam int SPL = DW / NL / 16;

  logic          hmc_clk = 1'b0;
  logic          hmc_res_n = 1'b0;
  logic          P_RST_N = 1'b0;
  logic          LXRXPS = 1'b1;
  logic          flit_valid = 1'b0;
  logic [DW-1:0] phy_data_tx_link2phy = '0;
  logic [DW-1:0] flit_data = '0;
  logic          LXTXPS, FERR_N, phy_rx_ready, flit_ready;
  logic [DW-1:0] phy_data_rx_phy2link;
  logic [2:0]    state_o;

  int n_checks = 0;
  int n_fail   = 0;

  hmc_link_init_responder #(
    .DWIDTH(DW), .NUM_LANES(NL), .T_INIT(TI), .T_RESP1(TR1), .T_RESP2(TR2),
    .NULL_DET(ND), .T_TIMEOUT(TTO), .T_PD(TPD)
  ) dut (
    .hmc_clk              (hmc_clk),
    .hmc_res_n            (hmc_res_n),
    .P_RST_N              (P_RST_N),
    .LXRXPS               (LXRXPS),
    .LXTXPS               (LXTXPS),
    .FERR_N               (FERR_N),
    .phy_data_tx_link2phy (phy_data_tx_link2phy),
    .phy_data_rx_phy2link (phy_data_rx_phy2link),
    .phy_rx_ready         (phy_rx_ready),
    .flit_data            (flit_data),
    .flit_valid           (flit_valid),
    .flit_ready           (flit_ready),
    .state_o              (state_o)
  );

  always #5 hmc_clk = ~hmc_clk;

  task automatic tick();
    @(posedge hmc_clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Expected TS1 word for the k-th TS1 cycle: slot number n carries n mod 16
  function automatic logic [DW-1:0] ts1_word(input int k);
    logic [DW-1:0] w;
    logic [3:0]    sq;
    w = '0;
    for (int l = 0; l < NL; l++) begin
      for (int s = 0; s < SPL; s++) begin
        sq = 4'((k*SPL + s) % 16);
        w[(l*SPL + s)*16 +: 16] = {8'hF0, 4'hC, sq};
      end
    end
    return w;
  endfunction

  // full: start with a P_RST_N pulse; zs: first TS1 cycle of controller zeros (<0 = never)
  task automatic run_training(input bit full, input int zs);
    int end_k;
    bit to_active;
    if (zs < 0) begin
      end_k = TTO; to_active = 1'b0;
    end else begin
      end_k = (zs + ND > TR2) ? zs + ND : TR2;
      to_active = (end_k <= TTO);
      if (!to_active) end_k = TTO;
    end
    if (full) begin
      P_RST_N = 1'b0; flit_valid = 1'b0;
      tick();
      n_checks++;
      if (state_o !== ST_RESET || flit_ready !== 1'b0 || phy_rx_ready !== 1'b0 || FERR_N !== 1'b1 || LXTXPS !== 1'b1) begin
        n_fail++;
        $display("FAIL train_reset: state=%0d flit_ready=%b rx_ready=%b FERR_N=%b LXTXPS=%b, required state=%0d 0 0 1 1",
                 state_o, flit_ready, phy_rx_ready, FERR_N, LXTXPS, ST_RESET);
      end
      P_RST_N = 1'b1; phy_data_tx_link2phy = '0;
      tick();
      for (int i = 0; i < TI; i++) begin
        n_checks++;
        if (state_o !== ST_INIT_WAIT || phy_rx_ready !== 1'b0 || phy_data_rx_phy2link !== '0) begin
          n_fail++;
          $display("FAIL init_wait[%0d]: state=%0d rx_ready=%b, required state=%0d rx_ready=0 data=0",
                   i, state_o, phy_rx_ready, ST_INIT_WAIT);
        end
        LXRXPS = 1'($urandom);
        tick();
      end
    end
    for (int i = 0; i < TR1; i++) begin
      n_checks++;
      if (state_o !== ST_NULL_TX || phy_rx_ready !== 1'b1 || flit_ready !== 1'b0 || phy_data_rx_phy2link !== '0) begin
        n_fail++;
        $display("FAIL null_tx[%0d]: state=%0d rx_ready=%b flit_ready=%b data=%0h, required state=%0d 1 0 data 0",
                 i, state_o, phy_rx_ready, flit_ready, phy_data_rx_phy2link, ST_NULL_TX);
      end
      LXRXPS = 1'($urandom);
      phy_data_tx_link2phy = '0;
      tick();
    end
    for (int k = 0; k < end_k; k++) begin
      n_checks++;
      if (state_o !== ST_TS1_TX || phy_rx_ready !== 1'b1 || flit_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL ts1_state[%0d]: state=%0d rx_ready=%b flit_ready=%b, required state=%0d 1 0",
                 k, state_o, phy_rx_ready, flit_ready, ST_TS1_TX);
      end
      n_checks++;
      if (phy_data_rx_phy2link !== ts1_word(k)) begin
        n_fail++;
        $display("FAIL ts1_data[%0d]: got %0h required %0h", k, phy_data_rx_phy2link, ts1_word(k));
      end
      phy_data_tx_link2phy = (zs >= 0 && k >= zs) ? '0 : (rand_word() | DW'(1));
      LXRXPS = 1'($urandom);
      tick();
    end
    n_checks++;
    if (to_active) begin
      if (state_o !== ST_ACTIVE || FERR_N !== 1'b1 || phy_rx_ready !== 1'b1 || flit_ready !== 1'b1 || phy_data_rx_phy2link !== '0) begin
        n_fail++;
        $display("FAIL train_active(zs=%0d): state=%0d FERR_N=%b rx_ready=%b flit_ready=%b, required state=%0d 1 1 1",
                 zs, state_o, FERR_N, phy_rx_ready, flit_ready, ST_ACTIVE);
      end
    end else begin
      if (state_o !== ST_ERROR || FERR_N !== 1'b0 || phy_rx_ready !== 1'b0 || flit_ready !== 1'b0 || phy_data_rx_phy2link !== '0) begin
        n_fail++;
        $display("FAIL train_error(zs=%0d): state=%0d FERR_N=%b rx_ready=%b flit_ready=%b, required state=%0d 0 0 0",
                 zs, state_o, FERR_N, phy_rx_ready, flit_ready, ST_ERROR);
      end
    end
    LXRXPS = 1'b1;
  endtask

  task automatic test_reset();
    hmc_res_n = 1'b0; P_RST_N = 1'b1;
    tick(); tick();
    n_checks++;
    if (state_o !== ST_RESET || LXTXPS !== 1'b1 || FERR_N !== 1'b1 || phy_rx_ready !== 1'b0 ||
        flit_ready !== 1'b0 || phy_data_rx_phy2link !== '0) begin
      n_fail++;
      $display("FAIL reset_values: state=%0d LXTXPS=%b FERR_N=%b rx_ready=%b flit_ready=%b data=%0h, required 0 1 1 0 0 0",
               state_o, LXTXPS, FERR_N, phy_rx_ready, flit_ready, phy_data_rx_phy2link);
    end
    hmc_res_n = 1'b1;
    tick();
    n_checks++;
    if (state_o !== ST_INIT_WAIT) begin
      n_fail++;
      $display("FAIL reset_release: state=%0d required %0d", state_o, ST_INIT_WAIT);
    end
  endtask

  task automatic test_active_flits(input int n);
    logic [DW-1:0] exp_q;
    exp_q = '0;
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (state_o !== ST_ACTIVE || flit_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL active_state[%0d]: state=%0d flit_ready=%b, required %0d 1", i, state_o, flit_ready, ST_ACTIVE);
      end
      n_checks++;
      if (phy_data_rx_phy2link !== exp_q) begin
        n_fail++;
        $display("FAIL active_data[%0d]: got %0h required %0h", i, phy_data_rx_phy2link, exp_q);
      end
      flit_valid = 1'($urandom);
      flit_data  = rand_word();
      exp_q      = flit_valid ? flit_data : '0;
      tick();
    end
    flit_valid = 1'b0;
  endtask

  task automatic test_reset_active();
    flit_valid = 1'b1; flit_data = rand_word() | DW'(1); P_RST_N = 1'b0;
    tick();
    n_checks++;
    if (state_o !== ST_RESET || flit_ready !== 1'b0 || phy_data_rx_phy2link !== '0) begin
      n_fail++;
      $display("FAIL reset_in_active: state=%0d flit_ready=%b data=%0h, required %0d 0 0",
               state_o, flit_ready, phy_data_rx_phy2link, ST_RESET);
    end
    flit_valid = 1'b0;
  endtask

  task automatic test_timeout();
    run_training(1'b1, -1);
    for (int i = 0; i < 4; i++) begin
      LXRXPS = 1'($urandom);
      tick();
      n_checks++;
      if (state_o !== ST_ERROR || FERR_N !== 1'b0 || phy_rx_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL error_hold[%0d]: state=%0d FERR_N=%b rx_ready=%b, required %0d 0 0",
                 i, state_o, FERR_N, phy_rx_ready, ST_ERROR);
      end
    end
    LXRXPS = 1'b1; P_RST_N = 1'b0;
    tick();
    n_checks++;
    if (state_o !== ST_RESET || FERR_N !== 1'b1) begin
      n_fail++;
      $display("FAIL error_exit: state=%0d FERR_N=%b, required %0d 1", state_o, FERR_N, ST_RESET);
    end
  endtask

  // low_cycles: number of cycles LXRXPS is held low, starting in ACTIVE
  task automatic test_sleep(input int low_cycles);
    LXRXPS = 1'b0; flit_valid = 1'b1; flit_data = rand_word();
    tick();
    for (int j = 0; j < low_cycles; j++) begin
      n_checks++;
      if (state_o !== ST_SLEEP || flit_ready !== 1'b0 || phy_data_rx_phy2link !== '0) begin
        n_fail++;
        $display("FAIL sleep_state[%0d]: state=%0d flit_ready=%b data=%0h, required %0d 0 0",
                 j, state_o, flit_ready, phy_data_rx_phy2link, ST_SLEEP);
      end
      n_checks++;
      if (LXTXPS !== 1'(j < TPD)) begin
        n_fail++;
        $display("FAIL sleep_lxtxps[%0d/%0d]: got %b required %b", j, low_cycles, LXTXPS, 1'(j < TPD));
      end
      LXRXPS     = (j == low_cycles - 1);
      flit_valid = 1'($urandom);
      flit_data  = rand_word();
      tick();
    end
    flit_valid = 1'b0;
    n_checks++;
    if (state_o !== ST_NULL_TX || LXTXPS !== 1'b1) begin
      n_fail++;
      $display("FAIL sleep_wake: state=%0d LXTXPS=%b, required %0d 1", state_o, LXTXPS, ST_NULL_TX);
    end
    run_training(1'b0, int'($urandom_range(0, TTO - ND)));
  endtask

  task automatic test_async_reset_ts1();
    P_RST_N = 1'b0;
    tick();
    P_RST_N = 1'b1; phy_data_tx_link2phy = rand_word() | DW'(1);
    for (int i = 0; i < 1 + TI + TR1 + 2; i++) tick();
    n_checks++;
    if (state_o !== ST_TS1_TX) begin
      n_fail++;
      $display("FAIL pre_async_reset: state=%0d required %0d", state_o, ST_TS1_TX);
    end
    #2 hmc_res_n = 1'b0;
    #1;
    n_checks++;
    if (state_o !== ST_RESET || phy_data_rx_phy2link !== '0 || phy_rx_ready !== 1'b0 || flit_ready !== 1'b0 || LXTXPS !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: state=%0d data=%0h rx_ready=%b flit_ready=%b LXTXPS=%b, required %0d 0 0 0 1",
               state_o, phy_data_rx_phy2link, phy_rx_ready, flit_ready, LXTXPS, ST_RESET);
    end
    tick();
    hmc_res_n = 1'b1;
    tick();
    n_checks++;
    if (state_o !== ST_INIT_WAIT) begin
      n_fail++;
      $display("FAIL async_reset_release: state=%0d required %0d", state_o, ST_INIT_WAIT);
    end
  endtask

  initial begin
    test_reset();
    run_training(1'b1, 5);            // nominal: ACTIVE at TS1 cycle 8
    test_active_flits(30);
    test_reset_active();
    test_timeout();
    run_training(1'b1, 9);            // TS1 runs past the seq wrap at cycle 8
    run_training(1'b1, TTO - ND);     // success and timeout on the same cycle
    run_training(1'b1, TTO - ND + 1); // zero run completes one cycle too late
    for (int r = 0; r < 6; r++) begin
      run_training(1'b1, ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TTO - ND + 1)));
    end
    run_training(1'b1, int'($urandom_range(0, TTO - ND)));
    test_active_flits(10);
    test_sleep(TPD + 3);
    test_sleep(3);
    test_sleep(TPD);
    test_sleep(TPD + 1);
    test_active_flits(5);
    test_async_reset_ts1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
